multi_cycle_adder: RTL and testbench



---
 rtl/multi_cycle_adder.sv | 159 +++++++++++++++
 tb/tb_multi_cycle_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_adder.sv
// Chunk-serial WIDTH-bit adder/subtractor: CHUNK bits per cycle with a registered inter-chunk carry.
// Optional subtract mode is built only when MULTI_CYCLE_ADDER_SUB_EN is defined.
module multi_cycle_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW    = CHUNK + 1;
  localparam int unsigned RW    = WIDTH + CHUNK;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   b_eff_c;
  logic               c0_c;
  logic [CW-1:0]      chunk_sum_c;
  logic               msb_cin_c;
  logic [RW-1:0]      res_cat_c;
  logic               last_c;

  // Operand mapping applied at capture time.
`ifdef MULTI_CYCLE_ADDER_SUB_EN
  assign b_eff_c = sub ? ~b : b;
  assign c0_c    = sub ? 1'b1 : cin;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign b_eff_c    = b;
  assign c0_c       = cin;
`endif

  // Operands shift right each cycle so the active chunk is always the low CHUNK bits.
  assign chunk_sum_c = CW'(a_q[CHUNK-1:0]) + CW'(b_q[CHUNK-1:0]) + CW'(carry_q);
  assign msb_cin_c   = chunk_sum_c[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
  assign res_cat_c   = {chunk_sum_c[CHUNK-1:0], res_q} >> CHUNK;
  assign last_c      = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b_eff_c;
          carry_d = c0_c;
          res_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum_c[CHUNK];
        res_d   = WIDTH'(res_cat_c);
        idx_d   = idx_q + IDX_W'(1);
        if (last_c) begin
          state_d = S_DONE;
          idx_d   = '0;
          carry_d = 1'b0;
          sum_d   = WIDTH'(res_cat_c);
          cout_d  = chunk_sum_c[CHUNK];
          ovf_d   = chunk_sum_c[CHUNK] ^ msb_cin_c;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        carry_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder: directed and random operations against an arithmetic reference model.
// Subtract expectations follow MULTI_CYCLE_ADDER_SUB_EN exactly as the design does.
module tb_multi_cycle_adder;

  localparam int unsigned W = 32;

`ifdef MULTI_CYCLE_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  logic         start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [W-1:0] a1 = '0, b1 = '0;
  logic         busy1, done1, cout1, ovf1;
  logic [W-1:0] sum1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  multi_cycle_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Reference: returns {ovf, cout, sum} from plain wide arithmetic and the sign rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] ye;
    logic         c0;
    logic [W:0]   full;
    logic         o;
    if (SUB_EN && s) begin
      ye = ~y;
      c0 = 1'b1;
    end else begin
      ye = y;
      c0 = ci;
    end
    full = {1'b0, x} + {1'b0, ye} + (W+1)'(c0);
    o    = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
    return {o, full};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the N=4 instance; called and returns at posedge+1.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s);
    logic [W+1:0] exp;
    logic [W-1:0] prev;
    int cyc, busy_cyc, held_bad;
    exp  = model(x, y, ci, s);
    prev = sum;
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    cyc = 0; busy_cyc = 0; held_bad = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cyc++;
      if (sum !== prev) held_bad++;
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'd4);
    check({tag, ".busy_cycles"}, 64'(busy_cyc), 64'd4);
    check({tag, ".sum_held"}, 64'(held_bad), 64'd0);
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".result"}, 64'({ovf, cout, sum}), 64'(exp));
    tick();
    check({tag, ".done_one_cycle"}, 64'(done), 64'd0);
  endtask

  // One operation on the N=1 instance.
  task automatic run_op1(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci);
    logic [W+1:0] exp;
    exp = model(x, y, ci, 1'b0);
    a1 = x; b1 = y; cin1 = ci; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1 = $urandom; b1 = $urandom;
    check({tag, ".busy"}, 64'({busy1, done1}), 64'b10);
    tick();
    check({tag, ".done"}, 64'({busy1, done1}), 64'b01);
    check({tag, ".result"}, 64'({ovf1, cout1, sum1}), 64'(exp));
  endtask

  initial begin
    logic [W+1:0] e1, e2;
    logic [W-1:0] got_sum;
    int cyc, lat, dcnt, d;

    #1;
    check("reset.outputs", 64'({busy, done, cout, ovf, sum}), 64'd0);
    check("reset.outputs_n1", 64'({busy1, done1, cout1, ovf1, sum1}), 64'd0);
    tick();
    rst_n = 1'b1;

    run_op("pc_inc", 32'h0040_0000, 32'd4, 1'b0, 1'b0);
    check("pc_inc.sum", 64'(sum), 64'h0040_0004);
    run_op("wrap1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    check("wrap1.const", 64'({ovf, cout, sum}), {30'd0, 2'b01, 32'h0});
    run_op("wrap_cin", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    check("wrap_cin.const", 64'({ovf, cout, sum}), {30'd0, 2'b01, 32'h0});
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    check("ovf_pos.const", 64'({ovf, cout, sum}), {30'd0, 2'b10, 32'h8000_0000});
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    check("ovf_neg.const", 64'({ovf, cout, sum}), {30'd0, 2'b11, 32'h0});

    run_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1);
    check("sub_5_7.sum", 64'(sum), SUB_EN ? 64'hFFFF_FFFE : 64'd12);
    run_op("sub_7_5", 32'd7, 32'd5, 1'b1, 1'b1);
    check("sub_7_5.sum", 64'({cout, sum}), SUB_EN ? {31'd0, 1'b1, 32'd2} : {31'd0, 1'b0, 32'd13});

    // Start pulsed mid-run is dropped.
    e1 = model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    tick();
    start = 1'b0;
    cyc = 3; lat = 0; dcnt = 0; got_sum = '0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) begin
        dcnt++;
        if (lat == 0) begin
          lat = cyc;
          got_sum = sum;
        end
      end
      tick();
      cyc++;
    end
    check("ignore.done_count", 64'(dcnt), 64'd1);
    check("ignore.latency", 64'(lat), 64'd4);
    check("ignore.sum", 64'(got_sum), 64'(e1[W-1:0]));

    // Start held through done launches the next op.
    e1 = model(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0);
    e2 = model(32'h0000_FFFF, 32'h0001_0001, 1'b1, 1'b0);
    a = 32'hA5A5_0F0F; b = 32'h5A5A_F0F1; cin = 1'b0; start = 1'b1;
    tick();
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b.first_latency", 64'(cyc), 64'd4);
    check("b2b.first_result", 64'({ovf, cout, sum}), 64'(e1));
    a = 32'h0000_FFFF; b = 32'h0001_0001; cin = 1'b1;
    d = 0;
    do begin
      tick();
      d++;
      if (d == 1) start = 1'b0;
    end while (done !== 1'b1 && d < 20);
    check("b2b.spacing", 64'(d), 64'd5);
    check("b2b.second_result", 64'({ovf, cout, sum}), 64'(e2));
    tick();

    // Asynchronous reset in the middle of an operation.
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs", 64'({busy, done, cout, ovf, sum}), 64'd0);
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    check("rst_mid.no_done", 64'(dcnt), 64'd0);
    run_op("after_rst", 32'd1, 32'd2, 1'b0, 1'b0);
    check("after_rst.sum", 64'(sum), 64'd3);

    for (int k = 0; k < 24; k++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom), 1'($urandom));
    end

    run_op1("n1_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op1("n1_ovf", 32'h7FFF_FFFF, 32'd0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_op1("n1_rand", $urandom, $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
